// File: rtl/ccsds_ldpc_enc_arbiter.sv
// Round-robin sharing of one bit-serial LDPC encoder between N_CH info streams.
// The grant unit is one whole codeblock; a queued channel ID tags the encoder output via m_axis_tuser.
module ccsds_ldpc_enc_arbiter #(
   parameter int N_CH     = 4,
   parameter int INFO_LEN = 7136,
   parameter int ID_DEPTH = 4,
   parameter int CH_W     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] s_axis_tdata,
   input  logic [N_CH-1:0] s_axis_tvalid,
   output logic [N_CH-1:0] s_axis_tready,
   output logic            enc_s_axis_tdata,
   output logic            enc_s_axis_tvalid,
   input  logic            enc_s_axis_tready,
   input  logic            enc_m_axis_tdata,
   input  logic            enc_m_axis_tvalid,
   input  logic            enc_m_axis_tlast,
   output logic            enc_m_axis_tready,
   output logic            m_axis_tdata,
   output logic            m_axis_tvalid,
   output logic            m_axis_tlast,
   output logic [CH_W-1:0] m_axis_tuser,
   input  logic            m_axis_tready,
   output logic            busy
);

   localparam int BIT_W = $clog2(INFO_LEN);
   localparam int PTR_W = $clog2(ID_DEPTH);

   typedef enum logic [0:0] {ARB = 1'b0, XFER = 1'b1} state_t;

   state_t            state_r;
   logic [CH_W-1:0]   grant_r;
   logic [CH_W-1:0]   last_grant_r;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [CH_W-1:0]   id_mem_r [ID_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    id_cnt_r;

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              out_run_s;
   logic              pick_found_s;
   logic [CH_W-1:0]   pick_ch_s;
   logic [CH_W:0]     pick_sum_s;
   logic              push_s;
   logic              pop_s;
   logic              in_hs_s;

   assign fifo_full_s  = (id_cnt_r == (PTR_W+1)'(ID_DEPTH));
   assign fifo_empty_s = (id_cnt_r == (PTR_W+1)'(0));
   assign out_run_s    = !rst && !fifo_empty_s;

   // Round-robin search starting one past the last completed grant, wrapping modulo N_CH.
   always_comb begin
      pick_found_s = 1'b0;
      pick_ch_s    = CH_W'(0);
      pick_sum_s   = (CH_W+1)'(0);
      for (int i = 1; i <= N_CH; i++) begin
         pick_sum_s = {1'b0, last_grant_r} + (CH_W+1)'(i);
         if (pick_sum_s >= (CH_W+1)'(N_CH)) begin
            pick_sum_s = pick_sum_s - (CH_W+1)'(N_CH);
         end else begin
            pick_sum_s = pick_sum_s;
         end
         if (!pick_found_s && s_axis_tvalid[pick_sum_s[CH_W-1:0]]) begin
            pick_found_s = 1'b1;
            pick_ch_s    = pick_sum_s[CH_W-1:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Input pass-through: only the granted channel sees the encoder's ready.
   always_comb begin
      s_axis_tready     = {N_CH{1'b0}};
      enc_s_axis_tdata  = 1'b0;
      enc_s_axis_tvalid = 1'b0;
      if (state_r == XFER && !rst) begin
         s_axis_tready[grant_r] = enc_s_axis_tready;
         enc_s_axis_tdata       = s_axis_tdata[grant_r];
         enc_s_axis_tvalid      = s_axis_tvalid[grant_r];
      end else begin
         s_axis_tready     = {N_CH{1'b0}};
         enc_s_axis_tdata  = 1'b0;
         enc_s_axis_tvalid = 1'b0;
      end
   end

   // Output side is held off whenever no block ID is outstanding.
   always_comb begin
      m_axis_tdata      = enc_m_axis_tdata;
      m_axis_tlast      = enc_m_axis_tlast && !rst;
      m_axis_tvalid     = enc_m_axis_tvalid && out_run_s;
      enc_m_axis_tready = m_axis_tready && out_run_s;
      m_axis_tuser      = out_run_s ? id_mem_r[rd_ptr_r] : CH_W'(0);
      busy              = !rst && ((state_r == XFER) || !fifo_empty_s);
   end

   assign push_s  = (state_r == ARB) && !fifo_full_s && pick_found_s;
   assign pop_s   = m_axis_tvalid && m_axis_tready && enc_m_axis_tlast;
   assign in_hs_s = enc_s_axis_tvalid && enc_s_axis_tready;

   // Grant FSM: one codeblock per grant, back to ARB after the last info bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ARB;
         grant_r      <= CH_W'(0);
         last_grant_r <= CH_W'(N_CH - 1);
         bit_cnt_r    <= BIT_W'(0);
      end else begin
         case (state_r)
            ARB: begin
               if (push_s) begin
                  grant_r <= pick_ch_s;
                  state_r <= XFER;
               end
            end
            XFER: begin
               if (in_hs_s) begin
                  if (bit_cnt_r == BIT_W'(INFO_LEN - 1)) begin
                     bit_cnt_r    <= BIT_W'(0);
                     last_grant_r <= grant_r;
                     state_r      <= ARB;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                  end
               end
            end
            default: state_r <= ARB;
         endcase
      end
   end

   // Channel-ID queue: push at grant, pop on the output block's tlast.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         id_cnt_r <= (PTR_W+1)'(0);
      end else begin
         if (push_s) begin
            id_mem_r[wr_ptr_r] <= pick_ch_s;
            wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   id_cnt_r <= id_cnt_r + (PTR_W+1)'(1);
            2'b01:   id_cnt_r <= id_cnt_r - (PTR_W+1)'(1);
            default: id_cnt_r <= id_cnt_r;
         endcase
      end
   end

endmodule

// File: tb/tb_ccsds_ldpc_enc_arbiter.sv
// Directed bench for ccsds_ldpc_enc_arbiter with a small k=16/n=24 behavioural encoder.
`timescale 1ns/1ps
module tb_ccsds_ldpc_enc_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] s_tdata = 4'd0;
   logic [3:0] s_tvalid = 4'd0;
   logic [3:0] s_tready;
   logic       enc_s_tdata, enc_s_tvalid;
   logic       enc_s_tready = 1'b1;
   logic       enc_m_tdata, enc_m_tvalid, enc_m_tlast, enc_m_tready;
   logic       m_tdata, m_tvalid, m_tlast;
   logic [1:0] m_tuser;
   logic       m_tready = 1'b0;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int in_ch[$];
   bit in_bit[$];
   int in_cyc[$];
   int out_user[$];
   bit out_data[$];
   bit out_last[$];
   int out_last_cyc[$];
   int multi_rdy = 0;

   bit ib[$];
   bit oqd[$];
   bit oql[$];

   ccsds_ldpc_enc_arbiter #(.N_CH(4), .INFO_LEN(16), .ID_DEPTH(2), .CH_W(2)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .enc_s_axis_tdata(enc_s_tdata), .enc_s_axis_tvalid(enc_s_tvalid), .enc_s_axis_tready(enc_s_tready),
      .enc_m_axis_tdata(enc_m_tdata), .enc_m_axis_tvalid(enc_m_tvalid), .enc_m_axis_tlast(enc_m_tlast),
      .enc_m_axis_tready(enc_m_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .m_axis_tready(m_tready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Systematic code: 16 info bits then 8 parity bits.
   function automatic bit enc_bit(input bit q[$], input int base, input int i);
      int j;
      if (i < 16) return q[base + i];
      j = i - 16;
      return q[base + j] ^ q[base + j + 8] ^ q[base + ((j + 3) % 16)];
   endfunction

   // Encoder model: accepts every bit, emits a 24-bit codeword once 16 bits are in.
   always @(posedge clk) begin
      if (rst) begin
         ib.delete(); oqd.delete(); oql.delete();
         enc_m_tvalid <= 1'b0; enc_m_tdata <= 1'b0; enc_m_tlast <= 1'b0;
      end else begin
         if (enc_m_tvalid && enc_m_tready) begin
            void'(oqd.pop_front()); void'(oql.pop_front());
         end
         if (enc_s_tvalid && enc_s_tready) begin
            ib.push_back(enc_s_tdata);
            if (ib.size() == 16) begin
               for (int i = 0; i < 24; i++) begin
                  oqd.push_back(enc_bit(ib, 0, i));
                  oql.push_back(i == 23);
               end
               ib.delete();
            end
         end
         enc_m_tvalid <= (oqd.size() != 0);
         enc_m_tdata  <= (oqd.size() != 0) ? oqd[0] : 1'b0;
         enc_m_tlast  <= (oql.size() != 0) ? oql[0] : 1'b0;
      end
   end

   // Records every handshake on both sides with its cycle number.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            if (s_tready[c] && s_tvalid[c]) begin
               in_ch.push_back(c); in_bit.push_back(s_tdata[c]); in_cyc.push_back(cyc);
            end
         end
         if (m_tvalid && m_tready) begin
            out_user.push_back(int'(m_tuser)); out_data.push_back(m_tdata); out_last.push_back(m_tlast);
            if (m_tlast) out_last_cyc.push_back(cyc);
         end
         if ($countones(s_tready) > 1) multi_rdy <= multi_rdy + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
      s_tdata = 4'($urandom);
   endtask

   task automatic wait_in(input int n, input int budget);
      int k = 0;
      while (in_ch.size() < n && k < budget) begin step(); k++; end
      chk("wait_in", 32'(in_ch.size() >= n), 32'd1);
   endtask

   task automatic wait_out(input int n, input int budget);
      int k = 0;
      while (out_last_cyc.size() < n && k < budget) begin step(); k++; end
      chk("wait_out", 32'(out_last_cyc.size() >= n), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 4'd0; m_tready = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   // Compares one output codeword with the encode of the recorded input block.
   task automatic chk_block(input string tag, input int ib_base, input int ob_base, input int user);
      int bad = 0;
      for (int i = 0; i < 24; i++) begin
         if (out_data[ob_base + i] !== enc_bit(in_bit, ib_base, i)) bad++;
         if (out_user[ob_base + i] != user) bad++;
         if (out_last[ob_base + i] !== (i == 23)) bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   task automatic same_ch(input string tag, input int base, input int len, input int ch);
      int bad = 0;
      for (int i = 0; i < len; i++) if (in_ch[base + i] != ch) bad++;
      chk(tag, 32'(bad), 32'd0);
   endtask

   int ib0, ob0, lb0;
   int exp_ord[5] = '{0, 1, 2, 3, 0};

   initial begin
      // Reset state
      step(); step();
      chk("rst_tready", 32'(s_tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_tready", 32'(s_tready), 32'd0);
      chk("post_rst_encv", 32'(enc_s_tvalid), 32'd0);
      chk("post_rst_mv", 32'(m_tvalid), 32'd0);
      chk("post_rst_mlast", 32'(m_tlast), 32'd0);
      chk("post_rst_tuser", 32'(m_tuser), 32'd0);
      chk("post_rst_emr", 32'(enc_m_tready), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // 1: only ch2, two blocks
      do_reset();
      ib0 = in_ch.size(); ob0 = out_user.size(); lb0 = out_last_cyc.size();
      m_tready = 1'b1; s_tvalid = 4'b0100;
      wait_in(ib0 + 32, 200);
      s_tvalid = 4'd0;
      same_ch("t1_ch2", ib0, 32, 2);
      chk("t1_count", 32'(in_ch.size() - ib0), 32'd32);
      chk("t1_gap", 32'(in_cyc[ib0 + 16] - in_cyc[ib0 + 15]), 32'd2);
      chk("t1_contig", 32'(in_cyc[ib0 + 15] - in_cyc[ib0]), 32'd15);
      wait_out(lb0 + 2, 200);
      chk("t1_outbits", 32'(out_user.size() - ob0), 32'd48);
      chk_block("t1_blk0", ib0, ob0, 2);
      chk_block("t1_blk1", ib0 + 16, ob0 + 24, 2);

      // 2: all channels, round-robin order
      do_reset();
      ib0 = in_ch.size(); ob0 = out_user.size(); lb0 = out_last_cyc.size();
      m_tready = 1'b1; s_tvalid = 4'hF;
      wait_in(ib0 + 80, 600);
      s_tvalid = 4'd0;
      for (int b = 0; b < 5; b++) same_ch("t2_order", ib0 + 16 * b, 16, exp_ord[b]);
      wait_out(lb0 + 5, 600);
      for (int b = 0; b < 5; b++) chk_block("t2_blk", ib0 + 16 * b, ob0 + 24 * b, exp_ord[b]);

      // 3: output stalled -> ID queue fills after two grants
      do_reset();
      ib0 = in_ch.size(); lb0 = out_last_cyc.size();
      m_tready = 1'b0; s_tvalid = 4'hF;
      repeat (100) step();
      chk("t3_grants", 32'(in_ch.size() - ib0), 32'd32);
      chk("t3_stall_rdy", 32'(s_tready), 32'd0);
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_mvalid", 32'(m_tvalid), 32'd1);
      chk("t3_emr", 32'(enc_m_tready), 32'd0);
      m_tready = 1'b1;
      wait_in(ib0 + 33, 200);
      s_tvalid = 4'd0;
      chk("t3_third_ch", 32'(in_ch[ib0 + 32]), 32'd2);
      chk("t3_after_pop", 32'(in_cyc[ib0 + 32] - out_last_cyc[lb0]), 32'd2);

      // 4: ch1 tvalid toggling mid-block
      do_reset();
      ib0 = in_ch.size(); ob0 = out_user.size(); lb0 = out_last_cyc.size();
      m_tready = 1'b1; s_tvalid = 4'b0010;
      for (int k = 0; k < 200 && in_ch.size() < ib0 + 16; k++) begin
         step();
         s_tvalid[1] = ~s_tvalid[1];
      end
      s_tvalid = 4'd0;
      chk("t4_count", 32'(in_ch.size() - ib0), 32'd16);
      same_ch("t4_ch1", ib0, 16, 1);
      chk("t4_span", 32'(in_cyc[ib0 + 15] - in_cyc[ib0]), 32'd30);
      wait_out(lb0 + 1, 200);
      chk_block("t4_blk", ib0, ob0, 1);

      // 5: reset in the middle of a ch3 block
      do_reset();
      ib0 = in_ch.size();
      m_tready = 1'b1; s_tvalid = 4'b1000;
      wait_in(ib0 + 7, 100);
      rst = 1'b1;
      step();
      chk("t5_rdy", 32'(s_tready), 32'd0);
      chk("t5_encv", 32'(enc_s_tvalid), 32'd0);
      chk("t5_mv", 32'(m_tvalid), 32'd0);
      rst = 1'b0; s_tvalid = 4'b1001;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rdy_arb", 32'(s_tready), 32'd0);
      wait_in(ib0 + 8, 50);
      chk("t5_ch0_first", 32'(in_ch[ib0 + 7]), 32'd0);

      // 6: last input bit coincides with previous block's tlast on a full queue
      do_reset();
      ib0 = in_ch.size(); ob0 = out_user.size(); lb0 = out_last_cyc.size();
      m_tready = 1'b0; s_tvalid = 4'b0011;
      wait_in(ib0 + 31, 200);
      s_tvalid = 4'd0;
      m_tready = 1'b1;
      repeat (23) step();
      s_tvalid = 4'b0011;
      step();
      chk("t6_count", 32'(in_ch.size() - ib0), 32'd32);
      chk("t6_coincide", 32'(out_last_cyc.size() > lb0 ? out_last_cyc[lb0] - in_cyc[ib0 + 31] : -1), 32'd0);
      wait_in(ib0 + 33, 50);
      chk("t6_next_ch", 32'(in_ch[ib0 + 32]), 32'd0);
      chk("t6_gap", 32'(in_cyc[ib0 + 32] - in_cyc[ib0 + 31]), 32'd2);
      wait_in(ib0 + 48, 100);
      s_tvalid = 4'd0;
      wait_out(lb0 + 3, 300);
      chk_block("t6_blkA", ib0, ob0, 0);
      chk_block("t6_blkB", ib0 + 16, ob0 + 24, 1);
      chk_block("t6_blkC", ib0 + 32, ob0 + 48, 0);

      chk("single_ready", 32'(multi_rdy), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
